// File: rtl/ss2_data_stack_16b.sv
// Sixteen-bit data stack: top-of-stack register (TR) plus a RAM of deeper
// entries addressed by a wrapping data pointer (DP).
module ss2_data_stack_16b #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [1:0]          dp_inc,
  input  logic                regWrite,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [WIDTH-1:0]    c,
  input  logic [WIDTH-1:0]    d,
  input  logic [WIDTH-1:0]    e,
  input  logic                tr_write,
  input  logic [2:0]          tr_src,
  output logic [WIDTH-1:0]    read_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    DP_HOLD = 2'b00,
    DP_PUSH = 2'b01,
    DP_POP  = 2'b10,
    DP_RSVD = 2'b11
  } dp_op_t;

  logic [WIDTH-1:0]      ram [DEPTH];
  logic [WIDTH-1:0]      tr;
  logic [WIDTH-1:0]      tr_next;
  logic [DEPTH_LOG2-1:0] dp;
  logic [DEPTH_LOG2-1:0] dp_next;
  logic [WIDTH-1:0]      ram_rd;
  dp_op_t                dp_op;

  assign dp_op  = dp_op_t'(dp_inc);
  assign ram_rd = ram[dp];

  // Pointer arithmetic wraps modulo the RAM depth; there are no full/empty flags.
  always_comb begin
    dp_next = dp;
    unique case (dp_op)
      DP_PUSH: dp_next = dp + 1'b1;
      DP_POP:  dp_next = dp - 1'b1;
      default: dp_next = dp;
    endcase
  end

  always_comb begin
    tr_next = tr;
    if (tr_write) begin
      unique case (tr_src)
        3'd0:    tr_next = a;
        3'd1:    tr_next = b;
        3'd2:    tr_next = c;
        3'd3:    tr_next = d;
        3'd4:    tr_next = e;
        3'd5:    tr_next = ram_rd;
        default: tr_next = tr;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      tr <= '0;
      dp <= '0;
    end else begin
      tr <= tr_next;
      dp <= dp_next;
    end
  end

  // RAM is not cleared by reset, but a write requested in the reset cycle is dropped.
  always_ff @(posedge CLK) begin
    if (!reset && regWrite) begin
      ram[dp_next] <= tr;
    end
  end

  assign read_data = tr;

endmodule

// File: tb/tb_ss2_data_stack_16b.sv
// Bench for ss2_data_stack_16b: stack model with per-word validity, a per-cycle
// compare process, and directed scenarios with literal expectations.
module tb_ss2_data_stack_16b;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  dp_inc = 2'b00;
  logic        regWrite = 1'b0;
  logic [15:0] a = '0, b = '0, c = '0, d = '0, e = '0;
  logic        tr_write = 1'b0;
  logic [2:0]  tr_src = 3'd0;
  logic [15:0] read_data;

  int n_cmp = 0;
  int n_bad = 0;

  ss2_data_stack_16b #(.WIDTH(16), .DEPTH_LOG2(8)) dut (
    .CLK(CLK), .reset(reset), .dp_inc(dp_inc), .regWrite(regWrite),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .tr_write(tr_write), .tr_src(tr_src), .read_data(read_data)
  );

  always #5 CLK = ~CLK;

  // Model: stack pointer, RAM image and a known-flag per word (RAM powers up unknown).
  logic [15:0] m_tr = '0;
  bit          m_tr_ok = 1'b0;
  logic [7:0]  m_dp = '0;
  logic [15:0] m_ram [256];
  bit          m_ok  [256];

  function automatic logic [7:0] nxt(input logic [7:0] p, input logic [1:0] op);
    if (op == 2'b01) return p + 8'd1;
    if (op == 2'b10) return p - 8'd1;
    return p;
  endfunction

  always @(posedge CLK) begin
    if (reset) begin
      m_tr    <= '0;
      m_tr_ok <= 1'b1;
      m_dp    <= '0;
    end else begin
      if (regWrite) begin
        m_ram[nxt(m_dp, dp_inc)] <= m_tr;
        m_ok[nxt(m_dp, dp_inc)]  <= m_tr_ok;
      end
      if (tr_write) begin
        case (tr_src)
          3'd0: m_tr <= a;
          3'd1: m_tr <= b;
          3'd2: m_tr <= c;
          3'd3: m_tr <= d;
          3'd4: m_tr <= e;
          3'd5: begin m_tr <= m_ram[m_dp]; m_tr_ok <= m_ok[m_dp]; end
          default: ;
        endcase
      end
      m_dp <= nxt(m_dp, dp_inc);
    end
  end

  always @(negedge CLK) begin
    if (m_tr_ok) begin
      n_cmp++;
      if (read_data !== m_tr) begin
        n_bad++;
        $display("FAIL model_tr t=%0t: got %h expected %h", $time, read_data, m_tr);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] exp);
    n_cmp++;
    if (read_data !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, read_data, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] inc, input logic rw,
                      input logic tw, input logic [2:0] src);
    reset = rst; dp_inc = inc; regWrite = rw; tr_write = tw; tr_src = src;
    @(posedge CLK);
    #1;
    reset = 1'b0; dp_inc = 2'b00; regWrite = 1'b0; tr_write = 1'b0; tr_src = 3'd0;
  endtask

  initial begin
    a = 16'd1; b = 16'd2; c = 16'd3; d = 16'd4; e = 16'd5;
    @(posedge CLK); #1;

    step(1, 2'b00, 0, 0, 3'd0);  chk("reset_tr", 16'd0);
    step(0, 2'b00, 0, 1, 3'd2);  chk("load_c", 16'd3);
    step(0, 2'b01, 1, 0, 3'd0);  chk("push_keeps_tr", 16'd3);   // DP=1, RAM[1]=3
    step(0, 2'b00, 0, 0, 3'd0);  chk("idle", 16'd3);
    step(0, 2'b00, 0, 1, 3'd4);  chk("load_e", 16'd5);
    step(0, 2'b10, 0, 1, 3'd5);  chk("pop", 16'd3);             // DP=0

    step(0, 2'b00, 0, 1, 3'd4);  chk("load_e2", 16'd5);
    a = 16'h1234;
    step(0, 2'b01, 1, 1, 3'd0);  chk("write_and_load", 16'h1234); // RAM[1]=5, DP=1
    step(0, 2'b10, 0, 1, 3'd5);  chk("pop_old_tr", 16'd5);         // DP=0

    step(0, 2'b00, 1, 0, 3'd0);                                   // RAM[0]=5 (overwrite in place)
    a = 16'hBEEF;
    step(0, 2'b00, 0, 1, 3'd0);  chk("load_beef", 16'hBEEF);
    step(0, 2'b10, 1, 0, 3'd0);  chk("wrap_write", 16'hBEEF);      // DP=255, RAM[255]=BEEF
    step(0, 2'b00, 0, 1, 3'd1);  chk("load_b", 16'd2);
    step(0, 2'b00, 0, 1, 3'd5);  chk("read_dp255", 16'hBEEF);
    step(0, 2'b01, 0, 0, 3'd0);                                   // DP wraps to 0
    step(0, 2'b00, 0, 1, 3'd5);  chk("read_dp0_after_wrap", 16'd5);

    step(0, 2'b00, 0, 1, 3'd2);  chk("load_c2", 16'd3);
    step(1, 2'b01, 1, 1, 3'd1);  chk("reset_priority", 16'd0);    // RAM write suppressed
    step(0, 2'b01, 0, 0, 3'd0);                                   // DP=1
    step(0, 2'b00, 0, 1, 3'd5);  chk("ram1_untouched_by_reset", 16'd5);
    step(0, 2'b00, 0, 1, 3'd6);  chk("src6_hold", 16'd5);
    step(0, 2'b00, 0, 1, 3'd7);  chk("src7_hold", 16'd5);
    step(0, 2'b00, 0, 0, 3'd0);  chk("tr_write0_hold", 16'd5);
    step(0, 2'b00, 0, 1, 3'd1);  chk("load_b2", 16'd2);
    step(0, 2'b00, 1, 0, 3'd0);                                   // RAM[1]=2
    step(0, 2'b00, 0, 1, 3'd0);  chk("load_a", 16'hBEEF);
    step(0, 2'b11, 0, 0, 3'd0);  chk("dp11_tr_hold", 16'hBEEF);
    step(0, 2'b00, 0, 1, 3'd5);  chk("dp11_dp_hold", 16'd2);

    // Mixed traffic checked only by the model compare process.
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
      d = 16'($urandom); e = 16'($urandom);
      step(($urandom_range(0, 39) == 0), 2'($urandom), 1'($urandom),
           1'($urandom), 3'($urandom_range(0, 7)));
    end

    @(negedge CLK); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
